ysyx_22050550_axi_arbiter: RTL and testbench

// Shares the core's single AXI4 master port between IFU/ICache refill (M0, read-only) and LSU/DCache+device path (M1, read+write).

---
 rtl/ysyx_22050550_axi_arbiter_pkg.sv | 19 +
 rtl/ysyx_22050550_axi_arbiter_rr_arb2.sv | 35 +++
 rtl/ysyx_22050550_axi_arbiter.sv | 255 +++++++++++++++++++++++++
 tb/tb_ysyx_22050550_axi_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22050550_axi_arbiter_pkg.sv
// Shared encodings for the core-side AXI arbiter: FSM states and AXI field constants.
package ysyx_22050550_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        RIDLE = 2'd0,
        RADDR = 2'd1,
        RDATA = 2'd2
    } rstate_e;

    typedef enum logic [1:0] {
        WIDLE = 2'd0,
        WDATA = 2'd1,
        WRESP = 2'd2
    } wstate_e;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

endpackage

// File: rtl/ysyx_22050550_axi_arbiter_rr_arb2.sv
// Two-requester arbiter with optional round-robin. The last grant is remembered only
// when the caller accepts a grant, so idle cycles do not disturb fairness.
module ysyx_22050550_rr_arb2 #(
    parameter int RR_EN = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update,
    output logic       grant,
    output logic       gnt_valid
);

    logic lastGrant_q, lastGrant_d;

    always_comb begin
        gnt_valid = |req;
        if (req == 2'b11) begin
            grant = (RR_EN != 0) ? ~lastGrant_q : 1'b1;
        end else begin
            grant = req[1];
        end
    end

    always_comb begin
        lastGrant_d = (update && gnt_valid) ? grant : lastGrant_q;
    end

    // Reset to M1 so that M0 wins the first tie.
    always_ff @(posedge clock) begin
        if (reset) lastGrant_q <= 1'b1;
        else       lastGrant_q <= lastGrant_d;
    end

endmodule

// File: rtl/ysyx_22050550_axi_arbiter.sv
// Shares one AXI4 master port between the IFU (M0, read-only) and the LSU (M1, read+write).
// Reads are arbitrated one transaction at a time; M1 writes go straight through.
module ysyx_22050550_axi_arbiter
    import ysyx_22050550_axi_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int RR_EN  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_ar_valid,
    input  logic [ADDR_W-1:0] m0_ar_addr,
    input  logic [7:0]        m0_ar_len,
    input  logic [2:0]        m0_ar_size,
    input  logic [1:0]        m0_ar_burst,
    output logic              m0_ar_ready,
    output logic              m0_r_valid,
    output logic [DATA_W-1:0] m0_r_data,
    output logic [1:0]        m0_r_resp,
    output logic              m0_r_last,
    input  logic              m0_r_ready,
    input  logic              m1_ar_valid,
    input  logic [ADDR_W-1:0] m1_ar_addr,
    input  logic [7:0]        m1_ar_len,
    input  logic [2:0]        m1_ar_size,
    input  logic [1:0]        m1_ar_burst,
    output logic              m1_ar_ready,
    output logic              m1_r_valid,
    output logic [DATA_W-1:0] m1_r_data,
    output logic [1:0]        m1_r_resp,
    output logic              m1_r_last,
    input  logic              m1_r_ready,
    input  logic              m1_aw_valid,
    input  logic [ADDR_W-1:0] m1_aw_addr,
    input  logic [7:0]        m1_aw_len,
    input  logic [2:0]        m1_aw_size,
    input  logic [1:0]        m1_aw_burst,
    output logic              m1_aw_ready,
    output logic              m1_w_ready,
    input  logic              m1_w_valid,
    input  logic [DATA_W-1:0] m1_w_data,
    input  logic [DATA_W/8-1:0] m1_w_strb,
    input  logic              m1_w_last,
    output logic              m1_b_valid,
    output logic [1:0]        m1_b_resp,
    input  logic              m1_b_ready,
    output logic              s_ar_valid,
    output logic [ADDR_W-1:0] s_ar_addr,
    output logic [7:0]        s_ar_len,
    output logic [2:0]        s_ar_size,
    output logic [1:0]        s_ar_burst,
    input  logic              s_ar_ready,
    output logic              s_aw_valid,
    output logic [ADDR_W-1:0] s_aw_addr,
    output logic [7:0]        s_aw_len,
    output logic [2:0]        s_aw_size,
    output logic [1:0]        s_aw_burst,
    input  logic              s_aw_ready,
    output logic              s_w_valid,
    output logic [DATA_W-1:0] s_w_data,
    output logic [DATA_W/8-1:0] s_w_strb,
    output logic              s_w_last,
    input  logic              s_w_ready,
    input  logic              s_r_valid,
    input  logic [DATA_W-1:0] s_r_data,
    input  logic [1:0]        s_r_resp,
    input  logic              s_r_last,
    output logic              s_r_ready,
    input  logic              s_b_valid,
    input  logic [1:0]        s_b_resp,
    output logic              s_b_ready,
    output logic              rd_owner,
    output logic              rd_err
);

    rstate_e    rstate_q, rstate_d;
    wstate_e    wstate_q, wstate_d;
    logic       rowner_q, rowner_d;
    logic [7:0] rlen_q, rlen_d;
    logic [7:0] beat_q, beat_d;
    logic       rerr_q, rerr_d;
    logic       grant, gntValid;

    // An M1 read must not overtake its own write still in flight.
    ysyx_22050550_rr_arb2 #(.RR_EN(RR_EN)) u_arb (
        .clock     (clock),
        .reset     (reset),
        .req       ({m1_ar_valid && (wstate_q == WIDLE), m0_ar_valid}),
        .update    (rstate_q == RIDLE),
        .grant     (grant),
        .gnt_valid (gntValid)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            rstate_q <= RIDLE;
            wstate_q <= WIDLE;
            rowner_q <= 1'b0;
            rlen_q   <= 8'd0;
            beat_q   <= 8'd0;
            rerr_q   <= 1'b0;
        end else begin
            rstate_q <= rstate_d;
            wstate_q <= wstate_d;
            rowner_q <= rowner_d;
            rlen_q   <= rlen_d;
            beat_q   <= beat_d;
            rerr_q   <= rerr_d;
        end
    end

    always_comb begin
        rstate_d = rstate_q;
        rowner_d = rowner_q;
        rlen_d   = rlen_q;
        beat_d   = beat_q;
        rerr_d   = rerr_q;
        case (rstate_q)
            RIDLE: begin
                if (s_r_valid) rerr_d = 1'b1;
                if (gntValid) begin
                    rstate_d = RADDR;
                    rowner_d = grant;
                end
            end
            RADDR: begin
                if (s_r_valid) rerr_d = 1'b1;
                if (s_ar_valid && s_ar_ready) begin
                    rlen_d   = rowner_q ? m1_ar_len : m0_ar_len;
                    beat_d   = 8'd0;
                    rstate_d = RDATA;
                end
            end
            RDATA: begin
                if (s_r_valid && s_r_ready) begin
                    beat_d = beat_q + 8'd1;
                    if ((beat_q > rlen_q) || (s_r_last && (beat_q != rlen_q))) rerr_d = 1'b1;
                    if (s_r_last) rstate_d = RIDLE;
                end
            end
            default: rstate_d = RIDLE;
        endcase
    end

    // Read channels are steered purely by the registered owner.
    always_comb begin
        s_ar_valid  = 1'b0;
        s_ar_addr   = '0;
        s_ar_len    = 8'd0;
        s_ar_size   = 3'd0;
        s_ar_burst  = 2'd0;
        m0_ar_ready = 1'b0;
        m1_ar_ready = 1'b0;
        s_r_ready   = 1'b0;
        m0_r_valid  = 1'b0;
        m0_r_data   = '0;
        m0_r_resp   = AXI_RESP_OKAY;
        m0_r_last   = 1'b0;
        m1_r_valid  = 1'b0;
        m1_r_data   = '0;
        m1_r_resp   = AXI_RESP_OKAY;
        m1_r_last   = 1'b0;
        case (rstate_q)
            RADDR: begin
                if (rowner_q) begin
                    s_ar_valid  = m1_ar_valid;
                    s_ar_addr   = m1_ar_addr;
                    s_ar_len    = m1_ar_len;
                    s_ar_size   = m1_ar_size;
                    s_ar_burst  = m1_ar_burst;
                    m1_ar_ready = s_ar_ready;
                end else begin
                    s_ar_valid  = m0_ar_valid;
                    s_ar_addr   = m0_ar_addr;
                    s_ar_len    = m0_ar_len;
                    s_ar_size   = m0_ar_size;
                    s_ar_burst  = m0_ar_burst;
                    m0_ar_ready = s_ar_ready;
                end
            end
            RDATA: begin
                if (rowner_q) begin
                    s_r_ready  = m1_r_ready;
                    m1_r_valid = s_r_valid;
                    m1_r_data  = s_r_data;
                    m1_r_resp  = s_r_resp;
                    m1_r_last  = s_r_last;
                end else begin
                    s_r_ready  = m0_r_ready;
                    m0_r_valid = s_r_valid;
                    m0_r_data  = s_r_data;
                    m0_r_resp  = s_r_resp;
                    m0_r_last  = s_r_last;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wstate_d = wstate_q;
        case (wstate_q)
            WIDLE:   if (m1_aw_valid && s_aw_ready)             wstate_d = WDATA;
            WDATA:   if (m1_w_valid && s_w_ready && m1_w_last)  wstate_d = WRESP;
            WRESP:   if (s_b_valid && m1_b_ready)               wstate_d = WIDLE;
            default: wstate_d = WIDLE;
        endcase
    end

    // W data is only forwarded after its address has been accepted.
    always_comb begin
        s_aw_valid  = 1'b0;
        s_aw_addr   = '0;
        s_aw_len    = 8'd0;
        s_aw_size   = 3'd0;
        s_aw_burst  = 2'd0;
        m1_aw_ready = 1'b0;
        s_w_valid   = 1'b0;
        s_w_data    = '0;
        s_w_strb    = '0;
        s_w_last    = 1'b0;
        m1_w_ready  = 1'b0;
        s_b_ready   = 1'b0;
        m1_b_valid  = 1'b0;
        m1_b_resp   = AXI_RESP_OKAY;
        case (wstate_q)
            WIDLE: begin
                s_aw_valid  = m1_aw_valid;
                s_aw_addr   = m1_aw_addr;
                s_aw_len    = m1_aw_len;
                s_aw_size   = m1_aw_size;
                s_aw_burst  = m1_aw_burst;
                m1_aw_ready = s_aw_ready;
            end
            WDATA: begin
                s_w_valid  = m1_w_valid;
                s_w_data   = m1_w_data;
                s_w_strb   = m1_w_strb;
                s_w_last   = m1_w_last;
                m1_w_ready = s_w_ready;
            end
            WRESP: begin
                s_b_ready  = m1_b_ready;
                m1_b_valid = s_b_valid;
                m1_b_resp  = s_b_resp;
            end
            default: ;
        endcase
    end

    assign rd_owner = rowner_q;
    assign rd_err   = rerr_q;

endmodule

// File: tb/tb_ysyx_22050550_axi_arbiter.sv
// Directed bench for the AXI arbiter: a round-robin instance and a fixed-priority
// instance share every input so both policies can be compared on the same traffic.
module tb_ysyx_22050550_axi_arbiter;
    import ysyx_22050550_axi_arbiter_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_ar_valid, m1_ar_valid, m1_aw_valid;
    logic [63:0] m0_ar_addr, m1_ar_addr, m1_aw_addr;
    logic [7:0]  m0_ar_len, m1_ar_len, m1_aw_len;
    logic [2:0]  m0_ar_size, m1_ar_size, m1_aw_size;
    logic [1:0]  m0_ar_burst, m1_ar_burst, m1_aw_burst;
    logic        m0_r_ready, m1_r_ready, m1_b_ready;
    logic        m1_w_valid, m1_w_last;
    logic [63:0] m1_w_data;
    logic [7:0]  m1_w_strb;
    logic        s_ar_ready, s_aw_ready, s_w_ready;
    logic        s_r_valid, s_r_last, s_b_valid;
    logic [63:0] s_r_data;
    logic [1:0]  s_r_resp, s_b_resp;

    logic        m0_ar_ready, m0_r_valid, m0_r_last, m1_ar_ready, m1_r_valid, m1_r_last;
    logic [63:0] m0_r_data, m1_r_data;
    logic [1:0]  m0_r_resp, m1_r_resp, m1_b_resp;
    logic        m1_aw_ready, m1_w_ready, m1_b_valid;
    logic        s_ar_valid, s_aw_valid, s_w_valid, s_w_last, s_r_ready, s_b_ready;
    logic [63:0] s_ar_addr, s_aw_addr, s_w_data;
    logic [7:0]  s_ar_len, s_aw_len, s_w_strb;
    logic [2:0]  s_ar_size, s_aw_size;
    logic [1:0]  s_ar_burst, s_aw_burst;
    logic        rd_owner, rd_err;

    logic        fp_m0_ar_ready, fp_m0_r_valid, fp_m0_r_last, fp_m1_ar_ready, fp_m1_r_valid, fp_m1_r_last;
    logic [63:0] fp_m0_r_data, fp_m1_r_data;
    logic [1:0]  fp_m0_r_resp, fp_m1_r_resp, fp_m1_b_resp;
    logic        fp_m1_aw_ready, fp_m1_w_ready, fp_m1_b_valid;
    logic        fp_s_ar_valid, fp_s_aw_valid, fp_s_w_valid, fp_s_w_last, fp_s_r_ready, fp_s_b_ready;
    logic [63:0] fp_s_ar_addr, fp_s_aw_addr, fp_s_w_data;
    logic [7:0]  fp_s_ar_len, fp_s_aw_len, fp_s_w_strb;
    logic [2:0]  fp_s_ar_size, fp_s_aw_size;
    logic [1:0]  fp_s_ar_burst, fp_s_aw_burst;
    logic        fp_rd_owner, fp_rd_err;

    int passCnt  = 0;
    int failCnt  = 0;
    int totalCnt = 0;

    always #5 clock = ~clock;

    ysyx_22050550_axi_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(1)) dut (
        .clock(clock), .reset(reset),
        .m0_ar_valid(m0_ar_valid), .m0_ar_addr(m0_ar_addr), .m0_ar_len(m0_ar_len),
        .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst), .m0_ar_ready(m0_ar_ready),
        .m0_r_valid(m0_r_valid), .m0_r_data(m0_r_data), .m0_r_resp(m0_r_resp),
        .m0_r_last(m0_r_last), .m0_r_ready(m0_r_ready),
        .m1_ar_valid(m1_ar_valid), .m1_ar_addr(m1_ar_addr), .m1_ar_len(m1_ar_len),
        .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst), .m1_ar_ready(m1_ar_ready),
        .m1_r_valid(m1_r_valid), .m1_r_data(m1_r_data), .m1_r_resp(m1_r_resp),
        .m1_r_last(m1_r_last), .m1_r_ready(m1_r_ready),
        .m1_aw_valid(m1_aw_valid), .m1_aw_addr(m1_aw_addr), .m1_aw_len(m1_aw_len),
        .m1_aw_size(m1_aw_size), .m1_aw_burst(m1_aw_burst), .m1_aw_ready(m1_aw_ready),
        .m1_w_ready(m1_w_ready), .m1_w_valid(m1_w_valid), .m1_w_data(m1_w_data),
        .m1_w_strb(m1_w_strb), .m1_w_last(m1_w_last),
        .m1_b_valid(m1_b_valid), .m1_b_resp(m1_b_resp), .m1_b_ready(m1_b_ready),
        .s_ar_valid(s_ar_valid), .s_ar_addr(s_ar_addr), .s_ar_len(s_ar_len),
        .s_ar_size(s_ar_size), .s_ar_burst(s_ar_burst), .s_ar_ready(s_ar_ready),
        .s_aw_valid(s_aw_valid), .s_aw_addr(s_aw_addr), .s_aw_len(s_aw_len),
        .s_aw_size(s_aw_size), .s_aw_burst(s_aw_burst), .s_aw_ready(s_aw_ready),
        .s_w_valid(s_w_valid), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
        .s_w_last(s_w_last), .s_w_ready(s_w_ready),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .s_r_last(s_r_last), .s_r_ready(s_r_ready),
        .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_ready(s_b_ready),
        .rd_owner(rd_owner), .rd_err(rd_err)
    );

    ysyx_22050550_axi_arbiter #(.ADDR_W(64), .DATA_W(64), .RR_EN(0)) dutFp (
        .clock(clock), .reset(reset),
        .m0_ar_valid(m0_ar_valid), .m0_ar_addr(m0_ar_addr), .m0_ar_len(m0_ar_len),
        .m0_ar_size(m0_ar_size), .m0_ar_burst(m0_ar_burst), .m0_ar_ready(fp_m0_ar_ready),
        .m0_r_valid(fp_m0_r_valid), .m0_r_data(fp_m0_r_data), .m0_r_resp(fp_m0_r_resp),
        .m0_r_last(fp_m0_r_last), .m0_r_ready(m0_r_ready),
        .m1_ar_valid(m1_ar_valid), .m1_ar_addr(m1_ar_addr), .m1_ar_len(m1_ar_len),
        .m1_ar_size(m1_ar_size), .m1_ar_burst(m1_ar_burst), .m1_ar_ready(fp_m1_ar_ready),
        .m1_r_valid(fp_m1_r_valid), .m1_r_data(fp_m1_r_data), .m1_r_resp(fp_m1_r_resp),
        .m1_r_last(fp_m1_r_last), .m1_r_ready(m1_r_ready),
        .m1_aw_valid(m1_aw_valid), .m1_aw_addr(m1_aw_addr), .m1_aw_len(m1_aw_len),
        .m1_aw_size(m1_aw_size), .m1_aw_burst(m1_aw_burst), .m1_aw_ready(fp_m1_aw_ready),
        .m1_w_ready(fp_m1_w_ready), .m1_w_valid(m1_w_valid), .m1_w_data(m1_w_data),
        .m1_w_strb(m1_w_strb), .m1_w_last(m1_w_last),
        .m1_b_valid(fp_m1_b_valid), .m1_b_resp(fp_m1_b_resp), .m1_b_ready(m1_b_ready),
        .s_ar_valid(fp_s_ar_valid), .s_ar_addr(fp_s_ar_addr), .s_ar_len(fp_s_ar_len),
        .s_ar_size(fp_s_ar_size), .s_ar_burst(fp_s_ar_burst), .s_ar_ready(s_ar_ready),
        .s_aw_valid(fp_s_aw_valid), .s_aw_addr(fp_s_aw_addr), .s_aw_len(fp_s_aw_len),
        .s_aw_size(fp_s_aw_size), .s_aw_burst(fp_s_aw_burst), .s_aw_ready(s_aw_ready),
        .s_w_valid(fp_s_w_valid), .s_w_data(fp_s_w_data), .s_w_strb(fp_s_w_strb),
        .s_w_last(fp_s_w_last), .s_w_ready(s_w_ready),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data), .s_r_resp(s_r_resp),
        .s_r_last(s_r_last), .s_r_ready(fp_s_r_ready),
        .s_b_valid(s_b_valid), .s_b_resp(s_b_resp), .s_b_ready(fp_s_b_ready),
        .rd_owner(fp_rd_owner), .rd_err(fp_rd_err)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Idles every input and pulses reset for two cycles.
    task automatic applyStimulus();
        reset = 1'b1;
        m0_ar_valid = 1'b0; m0_ar_addr = '0; m0_ar_len = '0; m0_ar_size = '0; m0_ar_burst = '0;
        m1_ar_valid = 1'b0; m1_ar_addr = '0; m1_ar_len = '0; m1_ar_size = '0; m1_ar_burst = '0;
        m1_aw_valid = 1'b0; m1_aw_addr = '0; m1_aw_len = '0; m1_aw_size = '0; m1_aw_burst = '0;
        m0_r_ready = 1'b1; m1_r_ready = 1'b1; m1_b_ready = 1'b0;
        m1_w_valid = 1'b0; m1_w_data = '0; m1_w_strb = '0; m1_w_last = 1'b0;
        s_ar_ready = 1'b0; s_aw_ready = 1'b0; s_w_ready = 1'b0;
        s_r_valid = 1'b0; s_r_data = '0; s_r_resp = '0; s_r_last = 1'b0;
        s_b_valid = 1'b0; s_b_resp = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        totalCnt++;
        assert (observed === expected) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    initial begin
        $display("[TB] starting AXI arbiter bench");
        applyStimulus();
        #1;
        checkOutput("reset s_ar_valid", s_ar_valid, 0);
        checkOutput("reset rd_owner", rd_owner, 0);
        checkOutput("reset rd_err", rd_err, 0);
        checkOutput("reset m0_r_valid", m0_r_valid, 0);
        checkOutput("reset s_b_ready", s_b_ready, 0);
        checkOutput("reset s_w_valid", s_w_valid, 0);
        checkOutput("reset s_aw_addr", s_aw_addr, 0);

        // Single M0 burst of four beats.
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_0000; m0_ar_len = 8'd3;
        m0_ar_size = 3'd3; m0_ar_burst = AXI_BURST_INCR; s_ar_ready = 1'b1;
        #1;
        checkOutput("m0 req cycle s_ar_valid", s_ar_valid, 0);
        checkOutput("m0 req cycle m0_ar_ready", m0_ar_ready, 0);
        tick();
        checkOutput("m0 raddr s_ar_valid", s_ar_valid, 1);
        checkOutput("m0 raddr s_ar_addr", s_ar_addr, 64'h8000_0000);
        checkOutput("m0 raddr s_ar_len", s_ar_len, 3);
        checkOutput("m0 raddr m0_ar_ready", m0_ar_ready, 1);
        checkOutput("m0 raddr m1_ar_ready", m1_ar_ready, 0);
        tick();
        m0_ar_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_r_valid = 1'b1; s_r_data = 64'h100 + 64'(i); s_r_last = (i == 3);
            #1;
            checkOutput("m0 beat r_valid", m0_r_valid, 1);
            checkOutput("m0 beat r_data", m0_r_data, 64'h100 + 64'(i));
            checkOutput("m0 beat m1_r_valid", m1_r_valid, 0);
            tick();
        end
        s_r_valid = 1'b0; s_r_last = 1'b0;
        #1;
        checkOutput("m0 burst rd_err", rd_err, 0);
        checkOutput("m0 burst done s_ar_valid", s_ar_valid, 0);

        // Contention: RR alternates M0,M1,M0; fixed priority always M1.
        applyStimulus();
        s_ar_ready = 1'b1;
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h1000;
        m1_ar_valid = 1'b1; m1_ar_addr = 64'h2000;
        for (int r = 0; r < 3; r++) begin
            s_r_valid = 1'b0; s_r_last = 1'b0;
            #1;
            checkOutput("contend idle s_ar_valid", s_ar_valid, 0);
            tick();
            checkOutput("rr owner", rd_owner, (r % 2 == 1));
            checkOutput("rr s_ar_addr", s_ar_addr, (r % 2 == 0) ? 64'h1000 : 64'h2000);
            checkOutput("fp owner", fp_rd_owner, 1);
            checkOutput("fp s_ar_addr", fp_s_ar_addr, 64'h2000);
            tick();
            s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 64'hD0 + 64'(r);
            #1;
            checkOutput("rr m0 r_valid", m0_r_valid, (r % 2 == 0));
            checkOutput("rr m1 r_valid", m1_r_valid, (r % 2 == 1));
            checkOutput("fp m1 r_valid", fp_m1_r_valid, 1);
            checkOutput("fp m0 r_valid", fp_m0_r_valid, 0);
            checkOutput("fp m1 r_data", fp_m1_r_data, 64'hD0 + 64'(r));
            tick();
        end
        m0_ar_valid = 1'b0; m1_ar_valid = 1'b0; s_r_valid = 1'b0; s_r_last = 1'b0;
        #1;
        checkOutput("contend rd_err", rd_err, 0);

        // M1 write followed by a read of the same address one cycle later.
        applyStimulus();
        s_aw_ready = 1'b1; s_ar_ready = 1'b1; m1_b_ready = 1'b1;
        m1_aw_valid = 1'b1; m1_aw_addr = 64'ha000_03f8; m1_aw_burst = AXI_BURST_INCR;
        m1_w_valid = 1'b1; m1_w_data = 64'h41; m1_w_strb = 8'h01; m1_w_last = 1'b1;
        s_w_ready = 1'b1;
        #1;
        checkOutput("aw s_aw_valid", s_aw_valid, 1);
        checkOutput("aw s_aw_addr", s_aw_addr, 64'ha000_03f8);
        checkOutput("aw m1_aw_ready", m1_aw_ready, 1);
        checkOutput("w before aw s_w_valid", s_w_valid, 0);
        checkOutput("w before aw m1_w_ready", m1_w_ready, 0);
        tick();
        m1_aw_valid = 1'b0;
        m1_ar_valid = 1'b1; m1_ar_addr = 64'ha000_03f8; m1_ar_len = 8'd0;
        #1;
        checkOutput("wdata s_w_valid", s_w_valid, 1);
        checkOutput("wdata s_w_data", s_w_data, 64'h41);
        checkOutput("wdata s_w_strb", s_w_strb, 8'h01);
        checkOutput("wdata s_aw_valid", s_aw_valid, 0);
        checkOutput("raw wdata s_ar_valid", s_ar_valid, 0);
        tick();
        m1_w_valid = 1'b0;
        #1;
        checkOutput("wresp s_b_ready", s_b_ready, 1);
        checkOutput("wresp m1_b_valid idle", m1_b_valid, 0);
        checkOutput("raw wresp s_ar_valid", s_ar_valid, 0);
        tick();
        s_b_valid = 1'b1; s_b_resp = AXI_RESP_OKAY;
        #1;
        checkOutput("b m1_b_valid", m1_b_valid, 1);
        checkOutput("raw b hs s_ar_valid", s_ar_valid, 0);
        tick();
        s_b_valid = 1'b0;
        #1;
        checkOutput("raw after b s_ar_valid", s_ar_valid, 0);
        checkOutput("after b s_b_ready", s_b_ready, 0);
        tick();
        checkOutput("raw read s_ar_valid", s_ar_valid, 1);
        checkOutput("raw read s_ar_addr", s_ar_addr, 64'ha000_03f8);
        checkOutput("raw read rd_owner", rd_owner, 1);
        tick();
        m1_ar_valid = 1'b0;
        s_r_valid = 1'b1; s_r_last = 1'b1; s_r_data = 64'h41;
        #1;
        checkOutput("raw read m1_r_data", m1_r_data, 64'h41);
        checkOutput("raw read m0_r_valid", m0_r_valid, 0);
        tick();
        s_r_valid = 1'b0; s_r_last = 1'b0;

        // Backpressure on ar with M1 waiting, then an early s_r_last.
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_0040; m0_ar_len = 8'd3; s_ar_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                m1_ar_valid = 1'b1; m1_ar_addr = 64'h3000; m1_ar_len = 8'd0;
            end
            #1;
            checkOutput("bp s_ar_valid", s_ar_valid, 1);
            checkOutput("bp rd_owner", rd_owner, 0);
            checkOutput("bp m0_ar_ready", m0_ar_ready, 0);
            tick();
        end
        s_ar_ready = 1'b1;
        #1;
        checkOutput("bp release m0_ar_ready", m0_ar_ready, 1);
        checkOutput("bp release s_ar_addr", s_ar_addr, 64'h8000_0040);
        tick();
        m0_ar_valid = 1'b0;
        s_r_valid = 1'b1; s_r_last = 1'b0;
        #1;
        checkOutput("short beat1 m0_r_valid", m0_r_valid, 1);
        tick();
        s_r_last = 1'b1;
        #1;
        checkOutput("short beat2 rd_err before", rd_err, 0);
        tick();
        s_r_valid = 1'b0; s_r_last = 1'b0;
        #1;
        checkOutput("short rd_err set", rd_err, 1);
        checkOutput("short idle s_ar_valid", s_ar_valid, 0);
        tick();
        checkOutput("after short rd_owner", rd_owner, 1);
        checkOutput("after short s_ar_addr", s_ar_addr, 64'h3000);
        tick();
        m1_ar_valid = 1'b0;
        s_r_valid = 1'b1; s_r_last = 1'b1;
        #1;
        checkOutput("after short m1_r_valid", m1_r_valid, 1);
        tick();
        s_r_valid = 1'b0; s_r_last = 1'b0;
        #1;
        checkOutput("rd_err sticky", rd_err, 1);
        checkOutput("fp rd_err sticky", fp_rd_err, 1);

        // Reset during the first data beat, then a fresh M0 transaction.
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_0080; m0_ar_len = 8'd3;
        tick();
        tick();
        m0_ar_valid = 1'b0;
        s_r_valid = 1'b1;
        #1;
        checkOutput("pre-reset m0_r_valid", m0_r_valid, 1);
        reset = 1'b1;
        tick();
        s_r_valid = 1'b0;
        reset = 1'b0;
        #1;
        checkOutput("mid reset m0_r_valid", m0_r_valid, 0);
        checkOutput("mid reset s_ar_valid", s_ar_valid, 0);
        checkOutput("mid reset s_r_ready", s_r_ready, 0);
        checkOutput("mid reset rd_err", rd_err, 0);
        checkOutput("mid reset rd_owner", rd_owner, 0);
        m0_ar_valid = 1'b1; m0_ar_addr = 64'h8000_00c0; m0_ar_len = 8'd1;
        tick();
        checkOutput("post reset s_ar_valid", s_ar_valid, 1);
        checkOutput("post reset s_ar_addr", s_ar_addr, 64'h8000_00c0);
        tick();
        m0_ar_valid = 1'b0;
        s_r_valid = 1'b1; s_r_last = 1'b0; s_r_data = 64'h55;
        #1;
        checkOutput("post reset beat0 data", m0_r_data, 64'h55);
        tick();
        s_r_last = 1'b1; s_r_data = 64'h66;
        #1;
        checkOutput("post reset beat1 last", m0_r_last, 1);
        tick();
        s_r_valid = 1'b0; s_r_last = 1'b0;
        #1;
        checkOutput("post reset rd_err", rd_err, 0);
        checkOutput("post reset idle s_ar_valid", s_ar_valid, 0);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
